// File: rtl/fft_coeff_pkg.sv
// ---------------------------------------------------------------------------
// fft_coeff_pkg
// Shared definitions for the FFT twiddle-coefficient stores: table geometry,
// the packed complex coefficient type and the loader state encoding.
// ---------------------------------------------------------------------------
package fft_coeff_pkg;

   localparam int SIZE = 32;              // entries per table
   localparam int CW   = 11;              // bits per real/imag component
   localparam int AW   = $clog2(SIZE);    // table address width

   // One table entry; re occupies the upper half of the packed word.
   typedef struct packed {
      logic [CW-1:0] re;
      logic [CW-1:0] im;
   } coeff_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,   // no usable table
      LOAD = 2'd1,   // accepting table writes
      PLAY = 2'd2    // table complete, cyclic playback
   } state_t;

endpackage

// File: rtl/coeff_dpram.sv
// ---------------------------------------------------------------------------
// coeff_dpram
// Simple dual-port RAM: one synchronous write port, one registered read port.
//   clk      rising-edge clock
//   rst      async active-low reset, clears the read register only
//   wr_en    write strobe; wr_data is stored at wr_addr on the clock edge
//   rd_en    read strobe; rd_data <= mem[rd_addr] on the clock edge
//   rd_data  registered read data, holds while rd_en is low
// ---------------------------------------------------------------------------
module coeff_dpram #(
   parameter int DEPTH = 32,
   parameter int WIDTH = 22,
   parameter int ABITS = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [ABITS-1:0] wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   input  logic [ABITS-1:0] rd_addr,
   output logic [WIDTH-1:0] rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];

   // NOTE: the storage array has no reset so it maps onto block RAM; only
   // the output register is reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_data <= '0;
      end else if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/coeff_ram_loader.sv
// ---------------------------------------------------------------------------
// coeff_ram_loader
// Writable twiddle-coefficient store. A full table is loaded over a
// valid/ready stream, then replayed cyclically one entry per rd_en.
//   clk          rising-edge clock
//   rst          async active-low reset (RAM contents are kept)
//   load_start   abort everything and begin a new table load
//   wr_valid     write entry offered
//   wr_ready     write accepted this cycle (high only while loading)
//   wr_data      entry {re, im}
//   wr_last      final entry of the load
//   rd_en        advance playback by one entry
//   coeff_out    current coefficient (one cycle after rd_en)
//   coeff_valid  coeff_out was updated this cycle
//   loaded       a complete table is present
//   load_err     sticky flag: the last load had the wrong length
// ---------------------------------------------------------------------------
module coeff_ram_loader #(
   parameter int SIZE = fft_coeff_pkg::SIZE,
   parameter int CW   = fft_coeff_pkg::CW,
   parameter int AW   = fft_coeff_pkg::AW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load_start,
   input  logic          wr_valid,
   output logic          wr_ready,
   input  logic [2*CW-1:0] wr_data,
   input  logic          wr_last,
   input  logic          rd_en,
   output logic [2*CW-1:0] coeff_out,
   output logic          coeff_valid,
   output logic          loaded,
   output logic          load_err
);

   import fft_coeff_pkg::*;

   localparam logic [AW-1:0] ADDR_ONE  = AW'(1);
   localparam logic [AW-1:0] ADDR_LAST = AW'(SIZE - 1);

   state_t        state;
   logic [AW-1:0] wr_addr;
   logic [AW-1:0] rd_addr;
   logic          wr_fire;
   logic          rd_fire;

   assign wr_ready = (state == LOAD);

   // load_start wins over any write or read sampled on the same edge.
   assign wr_fire = wr_valid && wr_ready && !load_start;
   assign rd_fire = rd_en && (state == PLAY) && !load_start;

   coeff_dpram #(
      .DEPTH (SIZE),
      .WIDTH (2*CW),
      .ABITS (AW)
   ) u_ram (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_fire),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_en   (rd_fire),
      .rd_addr (rd_addr),
      .rd_data (coeff_out)
   );

   // NOTE: all state here is updated with non-blocking assignments so every
   // register sees the pre-edge values of the others.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         wr_addr     <= '0;
         rd_addr     <= '0;
         coeff_valid <= 1'b0;
         loaded      <= 1'b0;
         load_err    <= 1'b0;
      end else if (load_start) begin
         state       <= LOAD;
         wr_addr     <= '0;
         rd_addr     <= '0;
         coeff_valid <= 1'b0;
         loaded      <= 1'b0;
         load_err    <= 1'b0;
      end else begin
         coeff_valid <= rd_fire;
         if (rd_fire) begin
            rd_addr <= (rd_addr == ADDR_LAST) ? '0 : rd_addr + ADDR_ONE;
         end
         if (wr_fire) begin
            wr_addr <= wr_addr + ADDR_ONE;
            // A table is good only if wr_last coincides with the final slot;
            // any other placement of wr_last, or its absence, is an error.
            if (wr_addr == ADDR_LAST && wr_last) begin
               state  <= PLAY;
               loaded <= 1'b1;
            end else if (wr_addr == ADDR_LAST || wr_last) begin
               state    <= IDLE;
               load_err <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_coeff_ram_loader.sv
// ---------------------------------------------------------------------------
// tb_coeff_ram_loader
// Directed sequences for load, playback, aborts and reset, a table of
// rd_en toggle vectors, and a randomized run checked against a
// transaction-level model of the coefficient store.
// ---------------------------------------------------------------------------
module tb_coeff_ram_loader;

   localparam int SIZE = 32;
   localparam int CW   = 11;

   logic            clk;
   logic            rst;
   logic            load_start;
   logic            wr_valid;
   logic            wr_ready;
   logic [2*CW-1:0] wr_data;
   logic            wr_last;
   logic            rd_en;
   logic [2*CW-1:0] coeff_out;
   logic            coeff_valid;
   logic            loaded;
   logic            load_err;

   coeff_ram_loader dut (
      .clk         (clk),
      .rst         (rst),
      .load_start  (load_start),
      .wr_valid    (wr_valid),
      .wr_ready    (wr_ready),
      .wr_data     (wr_data),
      .wr_last     (wr_last),
      .rd_en       (rd_en),
      .coeff_out   (coeff_out),
      .coeff_valid (coeff_valid),
      .loaded      (loaded),
      .load_err    (load_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [2*CW-1:0] pk(input int re, input int im);
      return {11'(re), 11'(im)};
   endfunction

   // ------------------------------------------------------------------
   // Reference model: a table, a load cursor and a playback cursor.
   // ------------------------------------------------------------------
   logic [2*CW-1:0] m_mem [SIZE];
   bit              m_loading, m_playing;
   int              m_cnt, m_rd;
   logic [2*CW-1:0] m_out;
   bit              m_valid, m_loaded, m_err;

   function automatic void model_reset();
      m_loading = 0; m_playing = 0; m_cnt = 0; m_rd = 0;
      m_out = '0; m_valid = 0; m_loaded = 0; m_err = 0;
   endfunction

   // Applies the inputs currently on the pins as one clock edge.
   function automatic void model_edge();
      if (!rst) begin
         model_reset();
      end else if (load_start) begin
         m_loading = 1; m_playing = 0; m_cnt = 0; m_rd = 0;
         m_valid = 0; m_loaded = 0; m_err = 0;
      end else if (m_loading) begin
         m_valid = 0;
         if (wr_valid) begin
            m_mem[m_cnt] = wr_data;
            if (m_cnt == SIZE - 1 && wr_last) begin
               m_loading = 0; m_playing = 1; m_loaded = 1;
            end else if (m_cnt == SIZE - 1 || wr_last) begin
               m_loading = 0; m_err = 1;
            end
            m_cnt++;
         end
      end else if (m_playing) begin
         m_valid = rd_en;
         if (rd_en) begin
            m_out = m_mem[m_rd];
            m_rd  = (m_rd + 1) % SIZE;
         end
      end else begin
         m_valid = 0;
      end
   endfunction

   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic check_model(input string tag);
      check({tag, ".wr_ready"},    wr_ready,    m_loading);
      check({tag, ".coeff_out"},   coeff_out,   m_out);
      check({tag, ".coeff_valid"}, coeff_valid, m_valid);
      check({tag, ".loaded"},      loaded,      m_loaded);
      check({tag, ".load_err"},    load_err,    m_err);
   endtask

   task automatic idle_inputs();
      load_start = 0; wr_valid = 0; wr_last = 0; rd_en = 0; wr_data = '0;
   endtask

   task automatic pulse_load_start();
      load_start = 1;
      tick();
      load_start = 0;
   endtask

   // Streams a full table of entries base_re+k / im_fn; returns accepts.
   task automatic load_table(input int base_re, input bit im_desc, output int acc);
      acc = 0;
      for (int k = 0; k < SIZE; k++) begin
         wr_valid = 1;
         wr_data  = pk(base_re + k, im_desc ? (SIZE - 1 - k) : k);
         wr_last  = (k == SIZE - 1);
         if (wr_ready) acc++;
         if (k == SIZE - 1) check("loaded_before_last_edge", loaded, 1'b0);
         tick();
      end
      wr_valid = 0; wr_last = 0;
   endtask

   typedef struct {
      logic rd_en;
      logic exp_valid;
      int   exp_idx;
   } toggle_vec_t;

   toggle_vec_t tv [6];
   int          acc;
   logic [2*CW-1:0] held;

   initial begin
      // rd_en toggle vectors; playback cursor is at entry 8 when applied.
      tv[0] = '{1'b1, 1'b1, 8};
      tv[1] = '{1'b0, 1'b0, 8};
      tv[2] = '{1'b1, 1'b1, 9};
      tv[3] = '{1'b0, 1'b0, 9};
      tv[4] = '{1'b0, 1'b0, 9};
      tv[5] = '{1'b1, 1'b1, 10};

      idle_inputs();
      rst = 0;
      model_reset();
      #12;
      check("rst.coeff_out",   coeff_out,   '0);
      check("rst.coeff_valid", coeff_valid, 1'b0);
      check("rst.loaded",      loaded,      1'b0);
      check("rst.load_err",    load_err,    1'b0);
      check("rst.wr_ready",    wr_ready,    1'b0);
      rst = 1;
      tick();
      check("idle.wr_ready", wr_ready, 1'b0);

      // Full load of {k, 31-k}.
      pulse_load_start();
      check("load.wr_ready", wr_ready, 1'b1);
      load_table(0, 1'b1, acc);
      check("load.accepts",  acc,      32);
      check("load.loaded",   loaded,   1'b1);
      check("load.load_err", load_err, 1'b0);
      check("load.wr_ready_after", wr_ready, 1'b0);

      // 40 back-to-back reads: 0..31 then 0..7, no wrap bubble.
      rd_en = 1;
      check("read.no_valid_same_cycle", coeff_valid, 1'b0);
      for (int i = 0; i < 40; i++) begin
         tick();
         check($sformatf("read%0d.coeff", i), coeff_out, pk(i % SIZE, SIZE - 1 - (i % SIZE)));
         check($sformatf("read%0d.valid", i), coeff_valid, 1'b1);
      end
      rd_en = 0;
      tick();
      check("read_stop.valid", coeff_valid, 1'b0);
      check("read_stop.hold",  coeff_out,   pk(7, 24));

      // Toggle table.
      for (int i = 0; i < 6; i++) begin
         rd_en = tv[i].rd_en;
         tick();
         check($sformatf("tog%0d.valid", i), coeff_valid, tv[i].exp_valid);
         check($sformatf("tog%0d.coeff", i), coeff_out, pk(tv[i].exp_idx, SIZE - 1 - tv[i].exp_idx));
      end

      // Advance to rd_addr 17, then abort with load_start plus a read.
      rd_en = 1;
      repeat (6) tick();
      check("pre_abort.coeff", coeff_out, pk(16, 15));
      load_start = 1;
      tick();
      load_start = 0; rd_en = 0;
      check("abort.loaded",   loaded,      1'b0);
      check("abort.valid",    coeff_valid, 1'b0);
      check("abort.hold",     coeff_out,   pk(16, 15));
      check("abort.wr_ready", wr_ready,    1'b1);
      load_table(100, 1'b0, acc);
      check("reload.accepts", acc,    32);
      check("reload.loaded",  loaded, 1'b1);
      rd_en = 1;
      tick();
      rd_en = 0;
      check("reload.first",       coeff_out,   pk(100, 0));
      check("reload.first_valid", coeff_valid, 1'b1);
      tick();

      // Short table: wr_last on the 10th entry.
      pulse_load_start();
      for (int k = 0; k < 10; k++) begin
         wr_valid = 1; wr_data = pk(500 + k, k); wr_last = (k == 9);
         tick();
      end
      wr_valid = 0; wr_last = 0;
      check("short.load_err", load_err, 1'b1);
      check("short.loaded",   loaded,   1'b0);
      check("short.wr_ready", wr_ready, 1'b0);
      rd_en = 1;
      tick();
      tick();
      rd_en = 0;
      check("short.rd_hold",  coeff_out,   pk(100, 0));
      check("short.rd_valid", coeff_valid, 1'b0);
      check_model("short");

      // Asynchronous reset in the middle of a load at wr_addr 5.
      pulse_load_start();
      for (int k = 0; k < 5; k++) begin
         wr_valid = 1; wr_data = pk(700 + k, k); wr_last = 0;
         tick();
      end
      check("midload.wr_ready", wr_ready, 1'b1);
      #2;
      rst = 0;
      model_reset();
      #1;
      check("async_rst.coeff_out",   coeff_out,   '0);
      check("async_rst.coeff_valid", coeff_valid, 1'b0);
      check("async_rst.loaded",      loaded,      1'b0);
      check("async_rst.load_err",    load_err,    1'b0);
      check("async_rst.wr_ready",    wr_ready,    1'b0);
      idle_inputs();
      wr_valid = 1;
      #1;
      rst = 1;
      tick();
      tick();
      check("post_rst.wr_ready", wr_ready, 1'b0);
      check("post_rst.loaded",   loaded,   1'b0);
      wr_valid = 0;

      // Randomized traffic against the model.
      for (int c = 0; c < 3000; c++) begin
         if (m_loading)      load_start = ($urandom_range(0, 299) == 0);
         else if (m_playing) load_start = ($urandom_range(0, 149) == 0);
         else                load_start = ($urandom_range(0, 5) == 0);
         wr_valid = ($urandom_range(0, 3) != 0);
         wr_data  = 22'($urandom);
         wr_last  = (m_cnt == SIZE - 1) ? ($urandom_range(0, 19) != 0)
                                        : ($urandom_range(0, 59) == 0);
         rd_en    = $urandom_range(0, 1);
         tick();
         check_model($sformatf("rand%0d", c));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/coeff_ram_loader.md
# coeff_ram_loader

- Writable twiddle-coefficient store for the FFT stages.
- A host or configuration path loads one full table of packed complex coefficients over a valid/ready write stream.
- Once the table is complete, the block replays it cyclically, one entry per enabled cycle, to the butterfly datapath.
- It is the write-side counterpart of the fixed coefficient ROMs, letting a stage's table be reprogrammed at run time.

## Interface
Parameters:
- SIZE, 32, number of table entries.
- CW, 11, width of each real/imag component; an entry is 2*CW bits.
- AW, $clog2(SIZE), address width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- load_start  in  1  aborts any activity and begins a new table load.
- wr_valid  in  1  write entry offered.
- wr_ready  out  1  block accepts a write this cycle.
- wr_data  in  2*CW  entry packed as {real[2*CW-1:CW], imag[CW-1:0]}.
- wr_last  in  1  marks the final entry of the load.
- rd_en  in  1  advance playback by one entry.
- coeff_out  out  2*CW  current coefficient.
- coeff_valid  out  1  coeff_out updated this cycle.
- loaded  out  1  a complete table is present.
- load_err  out  1  sticky; the last load was malformed.

## Operation
- States:
  - IDLE: reset state; no table.
  - LOAD: accepting writes.
  - PLAY: table complete; playback enabled.
- Reset (rst=0, asynchronous):
  - state=IDLE; wr_addr=0; rd_addr=0.
  - coeff_out=0, coeff_valid=0, loaded=0, load_err=0, wr_ready=0.
  - RAM contents are not cleared.
- load_start=1 in any state, sampled on clk: next state LOAD; wr_addr=0, rd_addr=0; loaded=0, load_err=0, coeff_valid=0. It overrides any write or read in the same cycle.
- LOAD:
  - wr_ready=1 combinationally from state; no dependence on wr_valid.
  - A write is accepted when wr_valid && wr_ready: mem[wr_addr] <= wr_data, and wr_addr increments.
  - Accept at wr_addr=SIZE-1 with wr_last=1: go to PLAY, loaded=1.
  - Accept at wr_addr=SIZE-1 with wr_last=0: load_err=1, go to IDLE.
  - Accept at wr_addr<SIZE-1 with wr_last=1 (short table): load_err=1, go to IDLE. The partial data is written but unusable.
- PLAY:
  - wr_ready=0, so writes are ignored.
  - rd_en=1: coeff_out <= mem[rd_addr], coeff_valid=1 next cycle. rd_addr increments and wraps SIZE-1 to 0.
  - rd_en=0: coeff_out holds, coeff_valid=0, rd_addr holds.
- IDLE: wr_ready=0; rd_en is ignored; coeff_out holds its last value.
- rd_en outside PLAY never changes coeff_out or rd_addr.

## Timing
- Write: one entry per cycle at full throughput. The entry is stored at the clock edge where the handshake occurs.
- Read latency: one cycle from an rd_en sample to the new coeff_out/coeff_valid, because the RAM read port is registered.
- loaded rises on the clock edge that accepts the final write. The first rd_en may arrive the following cycle, and its read returns mem[0].
- Back-to-back rd_en delivers entries 0,1,…,SIZE-1,0,1,… with no bubble at the wrap.
- Reset asserted mid-load or mid-playback takes effect immediately. Deassertion is synchronized externally.

## Structure
- Shared package fft_coeff_pkg holds:
  - CW, SIZE, AW.
  - typedef coeff_t (packed {re, im}, 2*CW bits).
  - state enum {IDLE, LOAD, PLAY}.
- Sub-module coeff_dpram: a simple dual-port RAM, SIZE x 2*CW, with one synchronous write port and one registered read port. No reset on the array.
- Top level contains the FSM, the wr_addr/rd_addr counters and the flag registers.

## Test plan
- Reset, then load 32 entries with value k = {11'dk, 11'd(31-k)}, wr_valid held high and wr_last on the 32nd:
  - 32 consecutive accepts; loaded=1 the cycle after the last; load_err=0.
- After loading, rd_en held high for 40 cycles:
  - coeff_out sequence is entries 0..31 then 0..7, with coeff_valid=1 every cycle from the cycle after the first rd_en.
  - 1-cycle latency is checked.
- Toggle rd_en 1,0,1,0 during playback:
  - coeff_out advances only on cycles following rd_en=1; it holds with coeff_valid=0 otherwise.
- wr_last asserted on the 10th entry:
  - load_err=1, loaded=0, state IDLE, wr_ready=0.
  - A subsequent rd_en leaves coeff_out unchanged.
- load_start pulsed during playback at rd_addr=17, then a full reload of values 100+k:
  - loaded drops the next cycle.
  - After reload, the first read returns entry 0 = 100.
- rst pulled low mid-load at wr_addr=5:
  - All outputs are 0 immediately (asynchronously).
  - After release, state is IDLE and wr_ready=0 until load_start.
